noc_vchannel_mux: RTL and testbench

// - Sits upstream of a router input port: merges VCHANNELS independent flit streams from a

---
 rtl/noc_vchannel_mux.sv | 135 +++++++++++++
 tb/tb_noc_vchannel_mux.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/noc_vchannel_mux.sv
// noc_vchannel_mux
//
// Merges VCHANNELS independent flit streams onto one physical link that feeds
// a router input port. Arbitration is flit-level round robin. The winner goes
// into a single registered output stage. That stage reloads on the same edge
// it drains, so the link can carry one flit per cycle.
//
// Parameters:
//   FLIT_WIDTH  flit data width in bits
//   VCHANNELS   number of virtual channels (>= 1)
//
// Ports:
//   clk        clock, all state on the rising edge
//   rst        asynchronous reset, active-low
//   in_flit    per-VC flit, packed [VCHANNELS-1:0][FLIT_WIDTH-1:0]
//   in_last    per-VC last-flit-of-packet marker
//   in_valid   per-VC flit valid
//   in_ready   per-VC accept, at most one bit high per cycle
//   out_flit   registered flit to the router
//   out_last   registered last marker
//   out_valid  registered valid, one-hot (VC of the held flit) or zero
//   out_ready  router per-VC ready; only the bit of the held VC matters
//
// Optional feature (define NOC_VCHANNEL_MUX_STATS_EN):
//   stat_flits  32-bit wrapping count of output transfers
//   stat_pkts   32-bit wrapping count of output transfers with out_last=1
// When the macro is not defined, these ports and counters are absent and the
// datapath is the same.

module noc_vchannel_mux #(
  parameter int FLIT_WIDTH = 32,
  parameter int VCHANNELS  = 1
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [VCHANNELS-1:0][FLIT_WIDTH-1:0] in_flit,
  input  logic [VCHANNELS-1:0]                 in_last,
  input  logic [VCHANNELS-1:0]                 in_valid,
  output logic [VCHANNELS-1:0]                 in_ready,
  output logic [FLIT_WIDTH-1:0]                out_flit,
  output logic                                 out_last,
  output logic [VCHANNELS-1:0]                 out_valid,
  input  logic [VCHANNELS-1:0]                 out_ready
`ifdef NOC_VCHANNEL_MUX_STATS_EN
  ,
  output logic [31:0]                          stat_flits,
  output logic [31:0]                          stat_pkts
`endif
);

  localparam int PTR_W = (VCHANNELS > 1) ? $clog2(VCHANNELS) : 1;

  logic [PTR_W-1:0]     ptr;
  logic [PTR_W-1:0]     grant_idx;
  logic [PTR_W-1:0]     scan_idx;
  logic [VCHANNELS-1:0] grant;
  logic                 found;
  logic                 occupied;
  logic                 out_xfer;
  logic                 load_en;
  logic                 in_xfer;

  // The pointer moves to the VC after the winner. When the winner is the last
  // VC it wraps to 0, so with one VC it always stays 0.
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] idx);
    if (idx == PTR_W'(VCHANNELS - 1)) begin
      next_ptr = '0;
    end else begin
      next_ptr = idx + PTR_W'(1);
    end
  endfunction

  // out_valid is one-hot, so OR-reducing the AND picks out the held VC's ready.
  assign occupied = |out_valid;
  assign out_xfer = |(out_valid & out_ready);
  assign load_en  = !occupied || out_xfer;

  // Scan cyclically from ptr. The first requester wins.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    scan_idx  = '0;
    found     = 1'b0;
    for (int i = 0; i < VCHANNELS; i++) begin
      scan_idx = PTR_W'((int'(ptr) + i) % VCHANNELS);
      if (!found && in_valid[scan_idx]) begin
        found           = 1'b1;
        grant[scan_idx] = 1'b1;
        grant_idx       = scan_idx;
      end
    end
  end

  assign in_ready = {VCHANNELS{rst && load_en}} & grant;
  assign in_xfer  = |in_ready;

  // Stage p0: the output register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_flit  <= '0;
      out_last  <= 1'b0;
      out_valid <= '0;
      ptr       <= '0;
    end else if (in_xfer) begin
      out_flit  <= in_flit[grant_idx];
      out_last  <= in_last[grant_idx];
      out_valid <= grant;
      ptr       <= next_ptr(grant_idx);
    end else if (out_xfer) begin
      // Only the valid clears here. The flit and last bits keep their old values.
      out_valid <= '0;
    end
  end

`ifdef NOC_VCHANNEL_MUX_STATS_EN
  logic [31:0] flit_cnt;
  logic [31:0] pkt_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      flit_cnt <= '0;
      pkt_cnt  <= '0;
    end else if (out_xfer) begin
      flit_cnt <= flit_cnt + 32'd1;
      if (out_last) begin
        pkt_cnt <= pkt_cnt + 32'd1;
      end
    end
  end

  assign stat_flits = flit_cnt;
  assign stat_pkts  = pkt_cnt;
`endif

endmodule

// File: tb/tb_noc_vchannel_mux.sv
// Testbench for noc_vchannel_mux with VCHANNELS=2 and FLIT_WIDTH=32.
//
// The reference model is an ordered list of flits the router should receive.
// It also keeps a notion of what the output register holds: zero or one
// entry, plus a round-robin pointer kept as an int. A monitor on the falling
// edge compares whatever the DUT presents against the head of the expected
// list and retires it when the router takes it.

module tb_noc_vchannel_mux;
  localparam int FW = 32;
  localparam int NV = 2;

  logic                   clk = 1'b0;
  logic                   rst = 1'b0;
  logic [NV-1:0][FW-1:0]  in_flit = '0;
  logic [NV-1:0]          in_last = '0;
  logic [NV-1:0]          in_valid = '0;
  logic [NV-1:0]          in_ready;
  logic [FW-1:0]          out_flit;
  logic                   out_last;
  logic [NV-1:0]          out_valid;
  logic [NV-1:0]          out_ready = '0;
`ifdef NOC_VCHANNEL_MUX_STATS_EN
  logic [31:0]            stat_flits;
  logic [31:0]            stat_pkts;
`endif

  noc_vchannel_mux #(.FLIT_WIDTH(FW), .VCHANNELS(NV)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_flit   (in_flit),
    .in_last   (in_last),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_flit  (out_flit),
    .out_last  (out_last),
    .out_valid (out_valid),
    .out_ready (out_ready)
`ifdef NOC_VCHANNEL_MUX_STATS_EN
    ,
    .stat_flits(stat_flits),
    .stat_pkts (stat_pkts)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int          vc;
    logic [31:0] flit;
    logic        last;
  } ent_t;

  ent_t sb_q[$];    // flits the router must still receive, in order
  ent_t hold_q[$];  // model of what is currently staged for output (0 or 1)
  int   mptr = 0;
  int   checks = 0;
  int   passes = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
  endtask

  // Monitor: every presented flit must be the oldest expected one.
  always @(negedge clk) begin
    if (rst && out_valid != '0) begin
      if (sb_q.size() == 0) begin
        check("spurious_out_valid", 64'(out_valid), 64'd0);
      end else begin
        check("out_valid", 64'(out_valid), 64'(2'b01 << sb_q[0].vc));
        check("out_flit", 64'(out_flit), 64'(sb_q[0].flit));
        check("out_last", 64'(out_last), 64'(sb_q[0].last));
        if ((out_valid & out_ready) != '0) void'(sb_q.pop_front());
      end
    end
  end

  // Called shortly after a rising edge. It drives one cycle of inputs, checks
  // in_ready against the model, updates the model for the coming edge, and
  // returns shortly after that edge. g reports the VC the model expects to win
  // (-1 if none).
  task automatic step(input logic [NV-1:0] v, input logic [NV-1:0] l,
                      input logic [NV-1:0] ordy, input logic [31:0] f0,
                      input logic [31:0] f1, output int g);
    bit   occ, ox, ld;
    ent_t e;
    logic [NV-1:0] exp_rdy;
    in_valid = v; in_last = l; out_ready = ordy;
    in_flit[0] = f0; in_flit[1] = f1;
    #1;
    occ = hold_q.size() > 0;
    ox  = occ && ordy[hold_q[0].vc];
    ld  = !occ || ox;
    g   = -1;
    if (ld) begin
      for (int i = 0; i < NV; i++) begin
        int c;
        c = (mptr + i) % NV;
        if (g < 0 && v[c]) g = c;
      end
    end
    exp_rdy = (g >= 0) ? NV'(1 << g) : '0;
    check("in_ready", 64'(in_ready), 64'(exp_rdy));
    if (ox) void'(hold_q.pop_front());
    if (g >= 0) begin
      e.vc = g; e.flit = (g == 1) ? f1 : f0; e.last = l[g];
      hold_q.push_back(e);
      sb_q.push_back(e);
      mptr = (g + 1) % NV;
    end
    @(posedge clk); #2;
  endtask

  task automatic drain();
    int g;
    for (int i = 0; i < 10; i++) begin
      if (hold_q.size() == 0) break;
      step('0, '0, '1, 32'h0, 32'h0, g);
    end
    check("drain_hold_empty", 64'(hold_q.size()), 64'd0);
  endtask

  task automatic do_reset();
    rst = 1'b0; in_valid = '0; out_ready = '0;
    sb_q.delete(); hold_q.delete(); mptr = 0;
    @(posedge clk); @(posedge clk); #2;
    rst = 1'b1;
  endtask

  initial begin
    int g, c0, c1, guard;

    // Reset state. in_valid is high the whole time, so in_ready must be held low.
    in_valid = 2'b11;
    repeat (3) @(posedge clk);
    #2;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_flit", 64'(out_flit), 64'd0);
    check("rst_out_last", 64'(out_last), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd0);
    in_valid = '0; rst = 1'b1;
    #1;
    check("idle_out_valid", 64'(out_valid), 64'd0);
    check("idle_in_ready", 64'(in_ready), 64'd0);
    @(posedge clk); #2;

    // Both VCs requesting and both ready: the output alternates 01,10,01,...
    for (int i = 0; i < 8; i++) begin
      step(2'b11, 2'b00, 2'b11, 32'h1000 + i, 32'h2000 + i, g);
      check("alt_out_valid", 64'(out_valid), (i % 2 == 0) ? 64'd1 : 64'd2);
    end
    drain();

    // Stall: hold a VC0 flit while only the other VC's ready is high.
    step(2'b01, 2'b00, 2'b00, 32'hA5A5A5A5, 32'h0, g);
    for (int i = 0; i < 5; i++) begin
      step(2'b11, 2'b00, 2'b10, 32'h11111111, 32'h22222222, g);
      check("stall_out_valid", 64'(out_valid), 64'd1);
      check("stall_out_flit", 64'(out_flit), 64'hA5A5A5A5);
    end
    step(2'b11, 2'b00, 2'b01, 32'h11111111, 32'h22222222, g);
    check("reload_out_valid", 64'(out_valid), 64'd2);
    check("reload_out_flit", 64'(out_flit), 64'h22222222);
    drain();

    // Interleaved packets: VC1 sends 4 flits and VC0 sends 2.
    c0 = 0; c1 = 0; guard = 0;
    while ((c0 < 2 || c1 < 4) && guard < 40) begin
      step({c1 < 4, c0 < 2}, {c1 == 3, c0 == 1}, NV'($urandom_range(1, 3)),
           32'h100 + c0, 32'h200 + c1, g);
      if (g == 0) c0++;
      if (g == 1) c1++;
      guard++;
    end
    check("pkt_done", 64'({c0[7:0], c1[7:0]}), 64'h0204);
    drain();

    // Asynchronous reset while a VC1 flit is held.
    step(2'b10, 2'b00, 2'b00, 32'h0, 32'hBEEF0001, g);
    step(2'b00, 2'b00, 2'b00, 32'h0, 32'h0, g);
    check("pre_rst_out_valid", 64'(out_valid), 64'd2);
    #1 rst = 1'b0;
    #1;
    check("async_rst_out_valid", 64'(out_valid), 64'd0);
    check("async_rst_in_ready", 64'(in_ready), 64'd0);
    sb_q.delete(); hold_q.delete(); mptr = 0;
    @(posedge clk); @(posedge clk); #2;
    rst = 1'b1;
    step(2'b11, 2'b00, 2'b00, 32'hC0C0C0C0, 32'hD0D0D0D0, g);
    check("post_rst_grant_vc0", 64'(out_valid), 64'd1);
    drain();

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      step(NV'($urandom_range(0, 3)), NV'($urandom_range(0, 3)),
           NV'($urandom_range(0, 3)), $urandom, $urandom, g);
    end
    drain();
    check("scoreboard_empty", 64'(sb_q.size()), 64'd0);

`ifdef NOC_VCHANNEL_MUX_STATS_EN
    do_reset();
    for (int p = 0; p < 3; p++) begin
      for (int f = 0; f < 4; f++) begin
        step(2'b01, {1'b0, f == 3}, 2'b11, 32'h300 + p * 4 + f, 32'h0, g);
      end
    end
    drain();
    check("stat_flits", 64'(stat_flits), 64'd12);
    check("stat_pkts", 64'(stat_pkts), 64'd3);
    force dut.flit_cnt = 32'hFFFFFFFE;
    #1 release dut.flit_cnt;
    step(2'b01, 2'b00, 2'b11, 32'h400, 32'h0, g);
    step(2'b01, 2'b00, 2'b11, 32'h401, 32'h0, g);
    drain();
    check("stat_flits_wrap", 64'(stat_flits), 64'd0);
`endif

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
